// File: rtl/pri_dec_acc_if.sv
// Beat-in / vector-out bundle for the accumulating priority-index decoder.
// Both handshakes are valid/ready: a transfer happens on a rising edge where valid && ready.
interface pri_dec_acc_if #(
  parameter int IN  = 16,
  parameter int OUT = $clog2(IN)
);
  logic           in_valid;
  logic           in_ready;
  logic [OUT-1:0] in_idx;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [IN-1:0]  out;
  logic [OUT:0]   out_cnt;
  logic           out_dup;
  logic           out_range;

  modport master (
    output in_valid, in_idx, in_last, out_ready,
    input  in_ready, out_valid, out, out_cnt, out_dup, out_range
  );

  modport slave (
    input  in_valid, in_idx, in_last, out_ready,
    output in_ready, out_valid, out, out_cnt, out_dup, out_range
  );
endinterface

// File: rtl/pri_dec_acc.sv
// Accumulating priority-index decoder: ORs one-hot decoded indices into a vector and
// publishes the completed vector, its popcount and duplicate/range flags on in_last.
module pri_dec_acc #(
  parameter int IN  = 16,
  parameter int OUT = $clog2(IN),
  parameter bit ACT = 1'b1  // 1: set bits read 1 on out, 0: set bits read 0
) (
  input  logic          clk,
  input  logic          reset_,
  pri_dec_acc_if.slave  bus,
  output logic          dbg_state
);
  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [IN-1:0] acc, acc_upd, onehot;
  logic [OUT:0]  cnt, cnt_upd;
  logic          dup_s, rng_s, dup_upd, rng_upd;
  logic          in_range, hit, beat, load;

  logic [IN-1:0] out_r;
  logic [OUT:0]  out_cnt_r;
  logic          out_dup_r, out_range_r;

  assign bus.in_ready  = (state == EMPTY) || bus.out_ready;
  assign bus.out_valid = (state == FULL);
  assign bus.out       = out_r;
  assign bus.out_cnt   = out_cnt_r;
  assign bus.out_dup   = out_dup_r;
  assign bus.out_range = out_range_r;
  assign dbg_state     = state;

  assign beat = bus.in_valid && bus.in_ready;
  assign load = beat && bus.in_last;

  // Unsigned compare at OUT+1 bits so indices >= IN never alias onto a real bit.
  assign in_range = ({1'b0, bus.in_idx} < (OUT+1)'(IN));

  always_comb begin
    onehot = '0;
    for (int i = 0; i < IN; i++) begin
      if ({1'b0, bus.in_idx} == (OUT+1)'(i)) onehot[i] = 1'b1;
    end
  end

  assign hit     = |(acc & onehot);
  assign acc_upd = acc | onehot;
  assign cnt_upd = cnt + (OUT+1)'(in_range && !hit);
  assign dup_upd = dup_s | (in_range && hit);
  assign rng_upd = rng_s | !in_range;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (load) state_nxt = FULL;
      FULL:  if (load) state_nxt = FULL;
             else if (bus.out_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) state <= EMPTY;
    else         state <= state_nxt;
  end

  // The in_last beat's own update goes to the output; the accumulator restarts empty.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      acc   <= '0;
      cnt   <= '0;
      dup_s <= 1'b0;
      rng_s <= 1'b0;
    end else if (beat) begin
      if (bus.in_last) begin
        acc   <= '0;
        cnt   <= '0;
        dup_s <= 1'b0;
        rng_s <= 1'b0;
      end else begin
        acc   <= acc_upd;
        cnt   <= cnt_upd;
        dup_s <= dup_upd;
        rng_s <= rng_upd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      out_r       <= {IN{~ACT}};
      out_cnt_r   <= '0;
      out_dup_r   <= 1'b0;
      out_range_r <= 1'b0;
    end else if (load) begin
      out_r       <= ACT ? acc_upd : ~acc_upd;
      out_cnt_r   <= cnt_upd;
      out_dup_r   <= dup_upd;
      out_range_r <= rng_upd;
    end
  end
endmodule

// File: tb/tb_pri_dec_acc.sv
// Bench for pri_dec_acc: a 16-bit active-high instance under randomized traffic with a
// scoreboard fed by a set-based model, and a 10-bit active-low instance under directed beats.
module tb_pri_dec_acc;
  logic clk = 1'b0;
  logic rst_a_, rst_b_;
  logic dbg_a, dbg_b;
  int   checks = 0;
  int   errors = 0;

  logic [22:0] exp_q[$];  // {dup, range, cnt[4:0], out[15:0]}
  bit          rand_ready = 1'b0;
  bit          ready_fixed = 1'b1;

  pri_dec_acc_if #(.IN(16), .OUT(4)) bus_a ();
  pri_dec_acc_if #(.IN(10), .OUT(4)) bus_b ();

  pri_dec_acc #(.IN(16), .OUT(4), .ACT(1'b1)) dut_a (
    .clk(clk), .reset_(rst_a_), .bus(bus_a), .dbg_state(dbg_a)
  );
  pri_dec_acc #(.IN(10), .OUT(4), .ACT(1'b0)) dut_b (
    .clk(clk), .reset_(rst_b_), .bus(bus_b), .dbg_state(dbg_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the vector is the set of distinct in-range indices seen.
  function automatic logic [22:0] model_a(input int idxs[$]);
    bit   seen[16];
    logic [15:0] v = '0;
    int   n = 0;
    bit   dup = 0, rng = 0;
    foreach (seen[k]) seen[k] = 0;
    foreach (idxs[k]) begin
      if (idxs[k] >= 16) rng = 1;
      else if (seen[idxs[k]]) dup = 1;
      else begin
        seen[idxs[k]] = 1;
        v = v | (16'h1 << idxs[k]);
        n++;
      end
    end
    return {dup, rng, 5'(n), v};
  endfunction

  always @(posedge clk) begin
    #1;
    bus_a.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  always @(negedge clk) begin
    if (rst_a_ === 1'b1 && bus_a.out_valid && bus_a.out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_vec", 32'(bus_a.out), 32'hdead);
      else begin
        logic [22:0] e;
        e = exp_q.pop_front();
        check("sb_out", 32'(bus_a.out), 32'(e[15:0]));
        check("sb_cnt", 32'(bus_a.out_cnt), 32'(e[20:16]));
        check("sb_range", 32'(bus_a.out_range), 32'(e[21]));
        check("sb_dup", 32'(bus_a.out_dup), 32'(e[22]));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send_beat_a(input int idx, input bit last, output bit ok);
    int t = 0;
    ok = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_idx   = 4'(idx);
    bus_a.in_last  = last;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = bus_a.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
    if (!ok) check("beat_accept_timeout", 0, 1);
    else if (last) check("lat_out_valid", 32'(bus_a.out_valid), 1);
  endtask

  task automatic send_vec_a(input int idxs[$]);
    bit ok;
    foreach (idxs[k]) begin
      send_beat_a(idxs[k], k == idxs.size() - 1, ok);
      if (ok && k == idxs.size() - 1) exp_q.push_back(model_a(idxs));
    end
  endtask

  task automatic drain_a();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_timeout", 32'(exp_q.size()), 0);
  endtask

  task automatic send_beat_b(input int idx, input bit last);
    int t = 0;
    bit ok = 0;
    bus_b.in_valid = 1'b1;
    bus_b.in_idx   = 4'(idx);
    bus_b.in_last  = last;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = bus_b.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus_b.in_valid = 1'b0;
    bus_b.in_last  = 1'b0;
    if (!ok) check("b_accept_timeout", 0, 1);
  endtask

  task automatic check_b(input string tag, input logic [9:0] v, input int n, input bit rng, input bit dup);
    check({tag, "_valid"}, 32'(bus_b.out_valid), 1);
    check({tag, "_out"}, 32'(bus_b.out), 32'(v));
    check({tag, "_cnt"}, 32'(bus_b.out_cnt), 32'(n));
    check({tag, "_range"}, 32'(bus_b.out_range), 32'(rng));
    check({tag, "_dup"}, 32'(bus_b.out_dup), 32'(dup));
  endtask

  initial begin
    int  q[$];
    bit  ok;
    logic [15:0] v;

    bus_a.in_valid = 1'b0; bus_a.in_idx = '0; bus_a.in_last = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_idx = '0; bus_b.in_last = 1'b0;
    bus_b.out_ready = 1'b1;
    rst_a_ = 1'b0;
    rst_b_ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_a_ = 1'b1;
    rst_b_ = 1'b1;
    @(negedge clk);
    check("rst_a_out", 32'(bus_a.out), 0);
    check("rst_a_valid", 32'(bus_a.out_valid), 0);
    check("rst_a_cnt", 32'(bus_a.out_cnt), 0);
    check("rst_a_in_ready", 32'(bus_a.in_ready), 1);
    check("rst_a_state", 32'(dbg_a), 0);
    check("rst_b_out", 32'(bus_b.out), 32'h3ff);
    check("rst_b_valid", 32'(bus_b.out_valid), 0);
    @(posedge clk);
    #1;

    // Single-index vectors, back-to-back.
    for (int i = 0; i < 16; i++) begin
      q = '{i};
      send_vec_a(q);
    end
    drain_a();

    // Multi-beat with a duplicate, then a fresh single-beat vector.
    q = '{3, 7, 3, 12};
    send_vec_a(q);
    q = '{0};
    send_vec_a(q);
    drain_a();

    // Back-pressure: vector 0x0005 held while beat 9 waits.
    ready_fixed = 1'b0;
    @(posedge clk);
    #1;
    q = '{0, 2};
    send_vec_a(q);
    fork
      begin
        q = '{9};
        send_vec_a(q);
      end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("stall_out", 32'(bus_a.out), 32'h0005);
          check("stall_in_ready", 32'(bus_a.in_ready), 0);
          check("stall_state", 32'(dbg_a), 1);
        end
        ready_fixed = 1'b1;
      end
    join
    drain_a();

    // Round trip: set bits of v serialised LSB-first.
    rand_ready = 1'b1;
    for (int n = 0; n < 1200; n++) begin
      v = (n == 0) ? 16'h0001 : (n == 1) ? 16'hffff : 16'($urandom_range(1, 65535));
      q = {};
      for (int b = 0; b < 16; b++) if (v[b]) q.push_back(b);
      send_vec_a(q);
    end
    // Random index streams, repeats allowed.
    for (int n = 0; n < 200; n++) begin
      q = {};
      for (int b = 0; b < int'($urandom_range(1, 6)); b++) q.push_back(int'($urandom_range(0, 15)));
      send_vec_a(q);
    end
    rand_ready = 1'b0;
    ready_fixed = 1'b1;
    drain_a();

    // Reset mid-vector discards the partial accumulation.
    send_beat_a(1, 1'b0, ok);
    send_beat_a(4, 1'b0, ok);
    rst_a_ = 1'b0;
    @(posedge clk);
    #1;
    rst_a_ = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(bus_a.out_valid), 0);
    check("midrst_out", 32'(bus_a.out), 0);
    @(posedge clk);
    #1;
    q = '{6};
    send_vec_a(q);
    drain_a();

    // Active-low, 10-bit instance with out-of-range indices.
    send_beat_b(2, 1'b0);
    send_beat_b(13, 1'b1);
    check_b("b_range", 10'h3fb, 1, 1'b1, 1'b0);
    send_beat_b(15, 1'b1);
    check_b("b_empty", 10'h3ff, 0, 1'b1, 1'b0);
    send_beat_b(9, 1'b0);
    send_beat_b(9, 1'b1);
    check_b("b_dup", 10'h1ff, 1, 1'b0, 1'b1);

    check("sb_leftover", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
